ap_ctrl_perf_monitor: RTL and testbench
=======================================

// Module: ap_ctrl_perf_monitor
// PURPOSE
//  Multi-channel performance monitor for HLS ap_ctrl handshakes (ap_start/ap_ready/ap_done/ap_continue).
//  Per channel: accepted transactions, start->done latency (last/min/max), start->start interval,
//  stall cycles and busy cycles. Handles pipelined kernels with up to FIFO_DEPTH starts outstanding.
//  Sits beside the kernel top in sim or emulation builds. Results are read through a registered mux port.
// PARAMETERS
//  NUM_CH      4   monitored channels (1..16)
//  CNT_W       32  width of timestamp, latency, interval and cycle counters
//  TXN_W       16  width of the transaction counter
//  FIFO_DEPTH  4   outstanding starts per channel (power of 2, >=2)
// PORTS
//  clock        in   1            single clock domain
//  reset        in   1            asynchronous, active-high
//  en           in   1            1 = leave IDLE and start counting
//  clear        in   1            synchronous clear of all statistics; returns FSM to IDLE
//  finish       in   1            end of test; FSM goes to FROZEN
//  ap_start     in   NUM_CH       per-channel kernel ap_start
//  ap_ready     in   NUM_CH       per-channel kernel ap_ready
//  ap_done      in   NUM_CH       per-channel kernel ap_done
//  ap_continue  in   NUM_CH       per-channel kernel ap_continue (tie 1 when unused)
//  rd_req       in   1            read strobe
//  rd_ch        in   $clog2(NUM_CH) channel to read
//  rd_sel       in   3            statistic select (see BEHAVIOUR)
//  rd_valid     out  1            rd_data valid; pulses 1 cycle after rd_req
//  rd_data      out  CNT_W        selected statistic, zero-extended
//  frozen       out  1            FSM is in FROZEN
//  err_any      out  1            OR of all sticky per-channel error flags
// BEHAVIOUR
//  Reset: FSM=IDLE; all counters 0; min_lat all-ones; FIFOs empty; rd_valid=0, rd_data=0, frozen=0, err_any=0.
//  Global FSM: IDLE -en-> RUN; RUN -finish-> FROZEN; any state -clear-> IDLE.
//   clear has priority over finish, and finish has priority over en.
//   Counting happens only in RUN. In IDLE and FROZEN, statistics hold and stay readable.
//  ts: free-running CNT_W timestamp, increments in RUN only, wraps. Differences are computed modulo 2^CNT_W.
//  Events per channel c: S = ap_start&ap_ready (start accepted); D = ap_done&ap_continue (done accepted).
//  S: push ts into fifo[c]; if a previous S exists, last_int = ts - prev_s_ts. prev_s_ts <= ts.
//  D, fifo non-empty: pop head h; lat = ts - h; update last_lat; min_lat = min(min_lat, lat); max_lat = max(max_lat, lat).
//  S and D in the same cycle:
//   - fifo empty: combinational kernel, lat = 0, nothing is pushed.
//   - fifo non-empty: pop the head and push ts in the same cycle. Legal even when the fifo is full.
//  D with empty fifo and no S: set sticky err_underflow[c]; statistics unchanged.
//  S with full fifo and no D: set sticky err_overflow[c]; timestamp dropped; txn_cnt still increments.
//  txn_cnt increments on each S. Each stall or busy cycle adds 1 to its counter.
//   - stall: ap_start & ~ap_ready.
//   - busy: fifo occupancy > 0.
//  All counters saturate at max value and do not wrap. Only ts wraps.
//  Statistic updates land 1 cycle after the event. A read returns values as of the cycle of rd_req.
//  rd_sel:
//   0 = txn_cnt
//   1 = last_lat
//   2 = min_lat
//   3 = max_lat
//   4 = last_int
//   5 = stall_cyc
//   6 = busy_cyc
//   7 = status {occupancy, err_overflow, err_underflow} in LSBs
//  rd_ch >= NUM_CH: rd_data = 0, rd_valid still pulses.
//  Async reset mid-operation: everything returns to reset values immediately; no partial state survives.
// STRUCTURE
//  Package ap_perf_pkg:
//   - typedef enum {ST_IDLE, ST_RUN, ST_FROZEN} mon_state_t
//   - localparams SEL_TXN..SEL_STATUS
//   - typedef struct ch_stats_t for the per-channel counters
//  Sub-module ts_fifo (DEPTH, W): simple synchronous FIFO with simultaneous push/pop, full, empty and count.
//   One instance per channel via generate.
//  Top: global FSM, ts counter, per-channel stats update logic, registered read mux.
// TESTING
//  1. Ch0 single: start/ready at ts=10, done at ts=17 -> txn=1, last/min/max_lat=7, occupancy 0, no errors.
//  2. Pipelined ch1: S at ts 5,6,7, D at ts 20,21,22 -> lat 15,15,15; last_int=1; peak occupancy 3.
//  3. Ch2, 5 S with no D (FIFO_DEPTH=4) -> err_overflow=1, err_any=1, txn=5, occupancy 4.
//  4. Ch3, same-cycle S and D with empty fifo -> lat=0, min_lat=0; D alone afterwards -> err_underflow=1.
//  5. ap_start high with ap_ready low for 6 cycles -> stall_cyc=6. finish asserted -> frozen=1 and counters hold. clear -> all 0, min_lat=all-ones.
//  6. Reset asserted mid-transaction with occupancy 2 -> next read returns 0 and status 0. rd_ch=NUM_CH -> rd_data=0.

Source files
------------

// File: rtl/ap_perf_pkg.sv
// rtl/ap_perf_pkg.sv - shared types and read-select codes for the ap_ctrl performance monitor
package ap_perf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FROZEN = 2'd2
    } mon_state_t;

    localparam logic [2:0] SEL_TXN      = 3'd0;
    localparam logic [2:0] SEL_LAST_LAT = 3'd1;
    localparam logic [2:0] SEL_MIN_LAT  = 3'd2;
    localparam logic [2:0] SEL_MAX_LAT  = 3'd3;
    localparam logic [2:0] SEL_LAST_INT = 3'd4;
    localparam logic [2:0] SEL_STALL    = 3'd5;
    localparam logic [2:0] SEL_BUSY     = 3'd6;
    localparam logic [2:0] SEL_STATUS   = 3'd7;

    localparam int DEF_CNT_W = 32;
    localparam int DEF_TXN_W = 16;

    // Per-channel statistics at the default counter widths
    typedef struct packed {
        logic [DEF_TXN_W-1:0] txn_cnt;
        logic [DEF_CNT_W-1:0] last_lat;
        logic [DEF_CNT_W-1:0] min_lat;
        logic [DEF_CNT_W-1:0] max_lat;
        logic [DEF_CNT_W-1:0] last_int;
        logic [DEF_CNT_W-1:0] stall_cyc;
        logic [DEF_CNT_W-1:0] busy_cyc;
        logic                 err_ovf;
        logic                 err_unf;
    } ch_stats_t;

endpackage

// File: rtl/ts_fifo.sv
// rtl/ts_fifo.sv - small synchronous FIFO of start timestamps with simultaneous push/pop
module ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [W-1:0]  i_data,
    output logic [W-1:0]  o_head,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    // A push into a full FIFO is only taken when the head leaves in the same cycle
    assign w_do_push = i_push & (~o_full | i_pop);
    assign w_do_pop  = i_pop & ~o_empty;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage needs no reset; pointers and count define what is valid
    always_ff @(posedge i_clock) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at power-of-2 depth
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ap_ctrl_perf_monitor.sv
// rtl/ap_ctrl_perf_monitor.sv - multi-channel ap_ctrl handshake performance monitor
module ap_ctrl_perf_monitor
    import ap_perf_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 32,
    parameter int TXN_W      = 16,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_en,
    input  logic              i_clear,
    input  logic              i_finish,
    input  logic [NUM_CH-1:0] i_ap_start,
    input  logic [NUM_CH-1:0] i_ap_ready,
    input  logic [NUM_CH-1:0] i_ap_done,
    input  logic [NUM_CH-1:0] i_ap_continue,
    input  logic              i_rd_req,
    input  logic [CH_W-1:0]   i_rd_ch,
    input  logic [2:0]        i_rd_sel,
    output logic              o_rd_valid,
    output logic [CNT_W-1:0]  o_rd_data,
    output logic              o_frozen,
    output logic              o_err_any
);

    localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [TXN_W-1:0] txn_cnt;
        logic [CNT_W-1:0] last_lat;
        logic [CNT_W-1:0] min_lat;
        logic [CNT_W-1:0] max_lat;
        logic [CNT_W-1:0] last_int;
        logic [CNT_W-1:0] stall_cyc;
        logic [CNT_W-1:0] busy_cyc;
        logic             err_ovf;
        logic             err_unf;
    } stats_t;

    mon_state_t       r_state;
    mon_state_t       w_state_nxt;
    logic             w_run;
    logic [CNT_W-1:0] r_ts;
    stats_t           w_init;
    stats_t           w_stats [NUM_CH];
    logic [OCC_W-1:0] w_occ   [NUM_CH];
    logic [NUM_CH-1:0] w_err;
    logic [CNT_W-1:0] w_rd_mux;
    logic             r_rd_valid;
    logic [CNT_W-1:0] r_rd_data;

    assign w_run     = (r_state == ST_RUN);
    assign o_frozen  = (r_state == ST_FROZEN);
    assign o_err_any = |w_err;
    assign o_rd_valid = r_rd_valid;
    assign o_rd_data  = r_rd_data;

    // Clean statistics: everything zero except min latency, which starts at all-ones
    always_comb begin
        w_init         = '0;
        w_init.min_lat = '1;
    end

    // Global state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: clear beats finish, finish beats en
    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:   if (!i_finish && i_en) w_state_nxt = ST_RUN;
                ST_RUN:    if (i_finish) w_state_nxt = ST_FROZEN;
                ST_FROZEN: w_state_nxt = ST_FROZEN;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Timestamp advances only while running and wraps freely
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ts <= '0;
        end else if (i_clear) begin
            r_ts <= '0;
        end else if (w_run) begin
            r_ts <= r_ts + CNT_W'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic             w_s;
        logic             w_d;
        logic             w_full;
        logic             w_empty;
        logic             w_push;
        logic             w_pop;
        logic             w_lat_upd;
        logic [CNT_W-1:0] w_head;
        logic [CNT_W-1:0] w_lat;
        logic [OCC_W-1:0] w_count;
        stats_t           r_st;
        logic [CNT_W-1:0] r_prev_s_ts;
        logic             r_have_prev;

        assign w_s = w_run & i_ap_start[c] & i_ap_ready[c];
        assign w_d = w_run & i_ap_done[c] & i_ap_continue[c];

        // A start and done in the same cycle on an empty FIFO is a zero-latency pass-through
        assign w_pop     = w_d & ~w_empty;
        assign w_push    = w_s & ~(w_d & w_empty) & (~w_full | w_d);
        assign w_lat_upd = w_d & (~w_empty | w_s);
        assign w_lat     = w_empty ? '0 : (r_ts - w_head);

        ts_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (CNT_W)
        ) u_fifo (
            .i_clock (i_clock),
            .i_reset (i_reset),
            .i_clear (i_clear),
            .i_push  (w_push),
            .i_pop   (w_pop),
            .i_data  (r_ts),
            .o_head  (w_head),
            .o_full  (w_full),
            .o_empty (w_empty),
            .o_count (w_count)
        );

        // Per-channel statistics; all counters saturate rather than wrap
        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                r_st        <= w_init;
                r_prev_s_ts <= '0;
                r_have_prev <= 1'b0;
            end else if (i_clear) begin
                r_st        <= w_init;
                r_prev_s_ts <= '0;
                r_have_prev <= 1'b0;
            end else if (w_run) begin
                if (w_s) begin
                    if (r_st.txn_cnt != '1) begin
                        r_st.txn_cnt <= r_st.txn_cnt + TXN_W'(1);
                    end
                    if (r_have_prev) begin
                        r_st.last_int <= r_ts - r_prev_s_ts;
                    end
                    r_prev_s_ts <= r_ts;
                    r_have_prev <= 1'b1;
                end
                if (w_lat_upd) begin
                    r_st.last_lat <= w_lat;
                    if (w_lat < r_st.min_lat) begin
                        r_st.min_lat <= w_lat;
                    end
                    if (w_lat > r_st.max_lat) begin
                        r_st.max_lat <= w_lat;
                    end
                end
                if (w_d && w_empty && !w_s) begin
                    r_st.err_unf <= 1'b1;
                end
                if (w_s && w_full && !w_d) begin
                    r_st.err_ovf <= 1'b1;
                end
                if (i_ap_start[c] && !i_ap_ready[c] && (r_st.stall_cyc != '1)) begin
                    r_st.stall_cyc <= r_st.stall_cyc + CNT_W'(1);
                end
                if ((w_count != '0) && (r_st.busy_cyc != '1)) begin
                    r_st.busy_cyc <= r_st.busy_cyc + CNT_W'(1);
                end
            end
        end

        assign w_stats[c] = r_st;
        assign w_occ[c]   = w_count;
        assign w_err[c]   = r_st.err_ovf | r_st.err_unf;
    end

    // Statistic select; a channel index beyond NUM_CH matches nothing and reads zero
    always_comb begin
        w_rd_mux = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (i_rd_ch == CH_W'(c)) begin
                case (i_rd_sel)
                    SEL_TXN:      w_rd_mux = CNT_W'(w_stats[c].txn_cnt);
                    SEL_LAST_LAT: w_rd_mux = w_stats[c].last_lat;
                    SEL_MIN_LAT:  w_rd_mux = w_stats[c].min_lat;
                    SEL_MAX_LAT:  w_rd_mux = w_stats[c].max_lat;
                    SEL_LAST_INT: w_rd_mux = w_stats[c].last_int;
                    SEL_STALL:    w_rd_mux = w_stats[c].stall_cyc;
                    SEL_BUSY:     w_rd_mux = w_stats[c].busy_cyc;
                    SEL_STATUS:   w_rd_mux = CNT_W'({w_occ[c], w_stats[c].err_ovf, w_stats[c].err_unf});
                    default:      w_rd_mux = '0;
                endcase
            end
        end
    end

    // Registered read port: data reflects the statistics in the cycle of the request
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= i_rd_req;
            if (i_rd_req) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_ap_ctrl_perf_monitor.sv
// tb/tb_ap_ctrl_perf_monitor.sv - directed self-checking bench for ap_ctrl_perf_monitor
module tb_ap_ctrl_perf_monitor;
    import ap_perf_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        fin = 1'b0;
    logic [3:0]  st = '0;
    logic [3:0]  rdy = '0;
    logic [3:0]  dn = '0;
    logic [3:0]  cont = 4'hF;
    logic        rd_req = 1'b0;
    logic [1:0]  rd_ch = '0;
    logic [2:0]  rd_sel = '0;
    logic        rv, frz, erra;
    logic [31:0] rdata;
    logic        rv3, frz3, erra3;
    logic [31:0] rdata3;

    int total = 0;
    int bad = 0;
    int cur_ts = 0;
    ch_stats_t exp2;

    always #5 clk = ~clk;

    ap_ctrl_perf_monitor #(.NUM_CH(4), .CNT_W(32), .TXN_W(16), .FIFO_DEPTH(4)) u_dut (
        .i_clock(clk), .i_reset(rst), .i_en(en), .i_clear(clr), .i_finish(fin),
        .i_ap_start(st), .i_ap_ready(rdy), .i_ap_done(dn), .i_ap_continue(cont),
        .i_rd_req(rd_req), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel),
        .o_rd_valid(rv), .o_rd_data(rdata), .o_frozen(frz), .o_err_any(erra)
    );

    ap_ctrl_perf_monitor #(.NUM_CH(3), .CNT_W(32), .TXN_W(16), .FIFO_DEPTH(4)) u_dut3 (
        .i_clock(clk), .i_reset(rst), .i_en(en), .i_clear(clr), .i_finish(fin),
        .i_ap_start(st[2:0]), .i_ap_ready(rdy[2:0]), .i_ap_done(dn[2:0]), .i_ap_continue(cont[2:0]),
        .i_rd_req(rd_req), .i_rd_ch(rd_ch), .i_rd_sel(rd_sel),
        .o_rd_valid(rv3), .o_rd_data(rdata3), .o_frozen(frz3), .o_err_any(erra3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cur_ts++;
    endtask

    task automatic run_to(input int k);
        while (cur_ts < k) tick();
    endtask

    task automatic start_run();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        en = 1'b1;
        tick();
        en = 1'b0;
        cur_ts = 0;
    endtask

    task automatic freeze();
        fin = 1'b1;
        tick();
        fin = 1'b0;
    endtask

    task automatic rd(input int ch, input logic [2:0] sel, input logic [31:0] exp, input string tag);
        rd_req = 1'b1;
        rd_ch = ch[1:0];
        rd_sel = sel;
        tick();
        check({tag, "_vld"}, {31'b0, rv}, 32'd1);
        check(tag, rdata, exp);
        rd_req = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        check("rst_vld", {31'b0, rv}, 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_frozen", {31'b0, frz}, 32'd0);
        check("rst_err", {31'b0, erra}, 32'd0);
        rd(0, SEL_MIN_LAT, 32'hFFFF_FFFF, "rst_min");
        rd(0, SEL_TXN, 32'd0, "rst_txn");
        tick();
        check("vld_idle_low", {31'b0, rv}, 32'd0);

        // 1: single transaction on ch0, start at 10, done at 17
        start_run();
        run_to(10);
        st[0] = 1'b1; rdy[0] = 1'b1;
        tick();
        st[0] = 1'b0; rdy[0] = 1'b0;
        run_to(17);
        dn[0] = 1'b1;
        tick();
        dn[0] = 1'b0;
        freeze();
        check("t1_frozen", {31'b0, frz}, 32'd1);
        rd(0, SEL_TXN, 32'd1, "t1_txn");
        rd(0, SEL_LAST_LAT, 32'd7, "t1_last");
        rd(0, SEL_MIN_LAT, 32'd7, "t1_min");
        rd(0, SEL_MAX_LAT, 32'd7, "t1_max");
        rd(0, SEL_BUSY, 32'd7, "t1_busy");
        rd(0, SEL_STATUS, 32'd0, "t1_status");
        check("t1_err", {31'b0, erra}, 32'd0);

        // 2: pipelined ch1, starts 5,6,7 and dones 20,21,22
        exp2 = '0;
        exp2.txn_cnt = 16'd3;
        exp2.last_lat = 32'd15;
        exp2.min_lat = 32'd15;
        exp2.max_lat = 32'd15;
        exp2.last_int = 32'd1;
        exp2.busy_cyc = 32'd17;
        start_run();
        run_to(5);
        st[1] = 1'b1; rdy[1] = 1'b1;
        repeat (3) tick();
        st[1] = 1'b0; rdy[1] = 1'b0;
        run_to(10);
        rd(1, SEL_STATUS, 32'd12, "t2_peak_occ");
        run_to(20);
        dn[1] = 1'b1;
        repeat (3) tick();
        dn[1] = 1'b0;
        freeze();
        rd(1, SEL_TXN, 32'(exp2.txn_cnt), "t2_txn");
        rd(1, SEL_LAST_LAT, exp2.last_lat, "t2_last");
        rd(1, SEL_MIN_LAT, exp2.min_lat, "t2_min");
        rd(1, SEL_MAX_LAT, exp2.max_lat, "t2_max");
        rd(1, SEL_LAST_INT, exp2.last_int, "t2_int");
        rd(1, SEL_BUSY, exp2.busy_cyc, "t2_busy");
        rd(1, SEL_STATUS, 32'd0, "t2_status");

        // 3: five starts on ch2 with no done overflow a depth-4 FIFO
        start_run();
        run_to(1);
        st[2] = 1'b1; rdy[2] = 1'b1;
        repeat (5) tick();
        st[2] = 1'b0; rdy[2] = 1'b0;
        freeze();
        rd(2, SEL_TXN, 32'd5, "t3_txn");
        rd(2, SEL_STATUS, 32'd18, "t3_status");
        rd(2, SEL_LAST_INT, 32'd1, "t3_int");
        check("t3_err_any", {31'b0, erra}, 32'd1);

        // 4: ch3 same-cycle start/done on empty FIFO, then a lone done
        start_run();
        check("t4_err_cleared", {31'b0, erra}, 32'd0);
        run_to(3);
        st[3] = 1'b1; rdy[3] = 1'b1; dn[3] = 1'b1;
        tick();
        st[3] = 1'b0; rdy[3] = 1'b0; dn[3] = 1'b0;
        run_to(6);
        dn[3] = 1'b1;
        tick();
        dn[3] = 1'b0;
        freeze();
        rd(3, SEL_LAST_LAT, 32'd0, "t4_last");
        rd(3, SEL_MIN_LAT, 32'd0, "t4_min");
        rd(3, SEL_MAX_LAT, 32'd0, "t4_max");
        rd(3, SEL_STATUS, 32'd1, "t4_status");
        check("t4_err_any", {31'b0, erra}, 32'd1);
        rd_req = 1'b1; rd_ch = 2'd3; rd_sel = SEL_TXN;
        tick();
        rd_req = 1'b0;
        check("t4_txn_ch3", rdata, 32'd1);
        check("oor_vld", {31'b0, rv3}, 32'd1);
        check("oor_data", rdata3, 32'd0);

        // 5: stall counting, freeze holds, clear restores reset values
        start_run();
        run_to(2);
        st[0] = 1'b1;
        repeat (6) tick();
        st[0] = 1'b0;
        freeze();
        check("t5_frozen", {31'b0, frz}, 32'd1);
        st[0] = 1'b1;
        repeat (4) tick();
        st[0] = 1'b0;
        rd(0, SEL_STALL, 32'd6, "t5_stall");
        rd(0, SEL_TXN, 32'd0, "t5_txn");
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t5_unfrozen", {31'b0, frz}, 32'd0);
        rd(0, SEL_STALL, 32'd0, "t5_clr_stall");
        rd(0, SEL_MIN_LAT, 32'hFFFF_FFFF, "t5_clr_min");
        rd(0, SEL_MAX_LAT, 32'd0, "t5_clr_max");

        // 6: asynchronous reset with two starts outstanding on ch1
        start_run();
        run_to(2);
        st[1] = 1'b1; rdy[1] = 1'b1;
        repeat (2) tick();
        st[1] = 1'b0; rdy[1] = 1'b0;
        run_to(5);
        rd(1, SEL_STATUS, 32'd8, "t6_occ2");
        rst = 1'b1;
        #1;
        check("t6_async_vld", {31'b0, rv}, 32'd0);
        check("t6_async_data", rdata, 32'd0);
        tick();
        rst = 1'b0;
        rd(1, SEL_TXN, 32'd0, "t6_txn");
        rd(1, SEL_STATUS, 32'd0, "t6_status");
        en = 1'b1;
        tick();
        en = 1'b0;
        cur_ts = 0;
        run_to(4);
        st[0] = 1'b1; rdy[0] = 1'b1;
        tick();
        st[0] = 1'b0; rdy[0] = 1'b0;
        run_to(9);
        dn[0] = 1'b1;
        tick();
        dn[0] = 1'b0;
        freeze();
        rd(0, SEL_LAST_LAT, 32'd5, "t6_post_lat");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
